// File: rtl/key_pkg.sv
// Shared defaults for the key debouncer: clock rate, sample tick and debounce/long-press limits.
package key_pkg;

    localparam int CLK_HZ         = 12_000_000;
    localparam int TICK_CYCLES    = CLK_HZ / 1000;
    localparam int DEBOUNCE_TICKS = 20;
    localparam int LONG_TICKS     = 1000;

    // Width for a counter that must hold 0..limit, with one spare bit of headroom.
    function automatic int ctr_width(input int limit);
        return $clog2(limit + 1) + 1;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, tick-sampled debounce and long-press detection.
module key_debounce_ch #(
    parameter int DEBOUNCE_TICKS = key_pkg::DEBOUNCE_TICKS,
    parameter int LONG_TICKS     = key_pkg::LONG_TICKS
) (
    input  logic clk_x1,
    input  logic rst,
    input  logic tick,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int SW = key_pkg::ctr_width(DEBOUNCE_TICKS);
    localparam int HW = key_pkg::ctr_width(LONG_TICKS);
    localparam logic [SW-1:0] DEB_LIMIT  = SW'(DEBOUNCE_TICKS);
    localparam logic [HW-1:0] LONG_LIMIT = HW'(LONG_TICKS);

    logic [1:0]    sync_n;
    logic [SW-1:0] stable_cnt;
    logic [SW-1:0] stable_next;
    logic [HW-1:0] held_cnt;
    logic          sample;

    assign sample      = ~sync_n[1];
    assign stable_next = stable_cnt + SW'(1);

    // NOTE: synchronizer resets to released (1), not 0, so reset exit never looks like a press.
    always_ff @(posedge clk_x1 or posedge rst) begin
        if (rst) begin
            sync_n <= 2'b11;
        end else begin
            sync_n <= {sync_n[0], key_n};
        end
    end

    always_ff @(posedge clk_x1 or posedge rst) begin
        if (rst) begin
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            stable_cnt  <= '0;
            held_cnt    <= '0;
        end else begin
            // NOTE: pulses default low every cycle so each one lasts exactly one clock.
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;

            if (tick) begin
                if (sample == key_level) begin
                    stable_cnt <= '0;
                end else if (stable_next == DEB_LIMIT) begin
                    key_level   <= sample;
                    key_press   <= sample;
                    key_release <= ~sample;
                    stable_cnt  <= '0;
                end else begin
                    stable_cnt <= stable_next;
                end
            end

            // Saturating at the limit is what keeps key_long to one pulse per press.
            if (!key_level) begin
                held_cnt <= '0;
            end else if (tick && held_cnt != LONG_LIMIT) begin
                held_cnt <= held_cnt + HW'(1);
                key_long <= (held_cnt + HW'(1) == LONG_LIMIT);
            end
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer: one shared sample-tick counter driving NKEY independent channels.
module key_debounce #(
    parameter int TICK_CYCLES    = key_pkg::TICK_CYCLES,
    parameter int DEBOUNCE_TICKS = key_pkg::DEBOUNCE_TICKS,
    parameter int LONG_TICKS     = key_pkg::LONG_TICKS,
    parameter int NKEY           = 4
) (
    input  logic            clk_x1,
    input  logic            rst,
    input  logic [NKEY-1:0] key_n,
    output logic [NKEY-1:0] key_level,
    output logic [NKEY-1:0] key_press,
    output logic [NKEY-1:0] key_release,
    output logic [NKEY-1:0] key_long
);

    localparam int TW = key_pkg::ctr_width(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk_x1 or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    for (genvar i = 0; i < NKEY; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
            .LONG_TICKS    (LONG_TICKS)
        ) u_ch (
            .clk_x1     (clk_x1),
            .rst        (rst),
            .tick       (tick),
            .key_n      (key_n[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with TICK_CYCLES=4, DEBOUNCE_TICKS=3, LONG_TICKS=10, NKEY=4.
module tb_key_debounce;

    localparam int TICK = 4;
    localparam int DEB  = 3;
    localparam int LONG = 10;

    typedef struct {
        string      name;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
        int         cyc;
    } ev_t;

    logic       clk_x1 = 1'b0;
    logic       rst    = 1'b1;
    logic [3:0] key_n  = 4'hF;
    logic [3:0] key_level, key_press, key_release, key_long;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  cyc    = 0;
    int  rel0   = 0;
    int  checks = 0;
    int  errors = 0;

    key_debounce #(
        .TICK_CYCLES   (TICK),
        .DEBOUNCE_TICKS(DEB),
        .LONG_TICKS    (LONG),
        .NKEY          (4)
    ) dut (
        .clk_x1     (clk_x1),
        .rst        (rst),
        .key_n      (key_n),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #5 clk_x1 = ~clk_x1;

    // Monitor: record every pulse with the count of rising edges seen so far.
    always @(negedge clk_x1) begin
        ev_t o;
        cyc = cyc + 1;
        if (!rst && (key_press | key_release | key_long) != 4'h0) begin
            o.name  = "obs";
            o.press = key_press;
            o.rel   = key_release;
            o.lng   = key_long;
            o.cyc   = cyc;
            obs_q.push_back(o);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(negedge clk_x1);
            #1;
        end
    endtask

    // Ticks fire on relative edges 4,8,12...; a level set after edge c reaches the sync output at c+2.
    function automatic int first_tick(input int c);
        return ((c + 3 + TICK - 1) / TICK) * TICK;
    endfunction

    task automatic expect_ev(input string name, input logic [3:0] p, input logic [3:0] r,
                             input logic [3:0] l, input int c);
        ev_t e;
        e.name  = name;
        e.press = p;
        e.rel   = r;
        e.lng   = l;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic compare_events(input string name);
        ev_t e;
        ev_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL %s/%s: got no event, required press=%b release=%b long=%b at cyc %0d",
                         name, e.name, e.press, e.rel, e.lng, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.press !== e.press || o.rel !== e.rel || o.lng !== e.lng || o.cyc != e.cyc) begin
                    errors++;
                    $display("FAIL %s/%s: got press=%b release=%b long=%b at cyc %0d, required press=%b release=%b long=%b at cyc %0d",
                             name, e.name, o.press, o.rel, o.lng, o.cyc, e.press, e.rel, e.lng, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s/extra: got %0d unexpected events (first press=%b release=%b long=%b at cyc %0d), required 0",
                     name, obs_q.size(), obs_q[0].press, obs_q[0].rel, obs_q[0].lng, obs_q[0].cyc);
            obs_q.delete();
        end
    endtask

    task automatic check_level(input string name, input logic [3:0] exp_level);
        checks++;
        if (key_level !== exp_level) begin
            errors++;
            $display("FAIL %s: key_level got %b, required %b", name, key_level, exp_level);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if ({key_level, key_press, key_release, key_long} !== 16'h0) begin
            errors++;
            $display("FAIL %s: outputs got %h, required 0000", name,
                     {key_level, key_press, key_release, key_long});
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        obs_q.delete();
        exp_q.delete();
        wait_cyc(3);
        rst  = 1'b0;
        rel0 = cyc;
    endtask

    task automatic test_reset();
        key_n = 4'hF;
        rst   = 1'b1;
        wait_cyc(3);
        check_all_zero("reset_active");
        rst  = 1'b0;
        rel0 = cyc;
        for (int i = 0; i < 100; i++) begin
            wait_cyc(1);
            check_all_zero("reset_idle");
        end
        compare_events("reset");
    endtask

    task automatic test_glitch();
        key_n = 4'hF;
        reset_dut();
        key_n[0] = 1'b0;
        wait_cyc(9);
        key_n[0] = 1'b1;
        wait_cyc(40);
        check_level("glitch_level", 4'b0000);
        compare_events("glitch");
    endtask

    task automatic test_press_long();
        key_n = 4'hF;
        reset_dut();
        key_n[1] = 1'b0;
        expect_ev("press", 4'b0010, 4'b0000, 4'b0000, rel0 + DEB * TICK);
        expect_ev("long",  4'b0000, 4'b0000, 4'b0010, rel0 + (DEB + LONG) * TICK);
        wait_cyc(14);
        check_level("long_level_on", 4'b0010);
        wait_cyc(46);
        key_n[1] = 1'b1;
        expect_ev("release", 4'b0000, 4'b0010, 4'b0000, rel0 + first_tick(60) + (DEB - 1) * TICK);
        wait_cyc(24);
        check_level("long_level_off", 4'b0000);
        compare_events("press_long");
    endtask

    task automatic test_short_press();
        key_n = 4'hF;
        reset_dut();
        key_n[2] = 1'b0;
        expect_ev("press", 4'b0100, 4'b0000, 4'b0000, rel0 + DEB * TICK);
        wait_cyc(24);
        key_n[2] = 1'b1;
        expect_ev("release", 4'b0000, 4'b0100, 4'b0000, rel0 + first_tick(24) + (DEB - 1) * TICK);
        wait_cyc(60);
        check_level("short_level", 4'b0000);
        compare_events("short_press");
    endtask

    task automatic test_back_to_back();
        key_n = 4'hF;
        reset_dut();
        key_n = 4'b0110;
        expect_ev("press", 4'b1001, 4'b0000, 4'b0000, rel0 + DEB * TICK);
        wait_cyc(14);
        check_level("multi_level_on", 4'b1001);
        wait_cyc(6);
        key_n = 4'hF;
        expect_ev("release", 4'b0000, 4'b1001, 4'b0000, rel0 + first_tick(20) + (DEB - 1) * TICK);
        wait_cyc(30);
        check_level("multi_level_off", 4'b0000);
        compare_events("simultaneous");
    endtask

    task automatic test_reset_mid_hold();
        key_n = 4'hF;
        reset_dut();
        key_n[1] = 1'b0;
        expect_ev("press1", 4'b0010, 4'b0000, 4'b0000, rel0 + DEB * TICK);
        wait_cyc(32);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_cyc(1);
            check_all_zero("midhold_rst");
        end
        rst  = 1'b0;
        rel0 = cyc;
        expect_ev("press2", 4'b0010, 4'b0000, 4'b0000, rel0 + DEB * TICK);
        expect_ev("long2",  4'b0000, 4'b0000, 4'b0010, rel0 + (DEB + LONG) * TICK);
        wait_cyc(60);
        key_n[1] = 1'b1;
        expect_ev("release2", 4'b0000, 4'b0010, 4'b0000, rel0 + first_tick(60) + (DEB - 1) * TICK);
        wait_cyc(24);
        compare_events("reset_mid_hold");
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press_long();
        test_short_press();
        test_back_to_back();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
